lane_ring_buffer: RTL and testbench

Multi-lane, burst-aware ring buffer between the DMA read engine and the VRSM compute lanes. One shared write stream carries a lane index and a burst-last marker. NUM_LANE independent first-word-fall-through (FWFT) rings each feed one consumer lane. Per-lane free-space and complete-burst status let the DMA issue a burst only when it fits.

---
 rtl/lane_ring_buffer_pkg.sv | 33 +++
 rtl/lane_ring_ctrl.sv | 76 +++++++
 rtl/lane_ring_buffer.sv | 98 +++++++++
 tb/tb_lane_ring_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_ring_buffer_pkg.sv
// Shared definitions for the multi-lane ring buffer.
//   DEF_*        default configuration values
//   lane_w/ptr_w/bcnt_w  derived widths, computed from the configuration
//   entry_t      one stored beat: burst-last marker plus payload
package lane_ring_buffer_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_BURST_LENGTH = 128;
    localparam int DEF_NUM_LANE     = 4;
    localparam int DEF_DEPTH_BURSTS = 2;

    // Width of the lane index carried on the write stream.
    function automatic int lane_w(input int num_lane);
        return $clog2(num_lane);
    endfunction

    // Address bits of one ring (the pointers carry one extra wrap bit).
    function automatic int ptr_w(input int burst_length, input int depth_bursts);
        return $clog2(burst_length * depth_bursts);
    endfunction

    // Burst counter width: sized so DEPTH complete bursts still fit.
    function automatic int bcnt_w(input int burst_length, input int depth_bursts);
        return $clog2(burst_length * depth_bursts) + 1;
    endfunction

    // Storage entries are built on the default payload width.
    typedef struct packed {
        logic                      last;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/lane_ring_ctrl.sv
// Pointer, occupancy and burst bookkeeping for one lane of the ring buffer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_last beat accepted into this lane this cycle, and its last flag
//   pop_req         consumer ready for this lane
//   head_last       last flag of the entry at the read pointer
//   flush           synchronous clear of this lane
//   waddr, raddr    storage addresses (wrap bit dropped)
//   count           entries held
//   valid, full     head valid / no free entry
//   burst_space     at least one burst of free entries
//   bursts_avail    complete bursts held
module lane_ring_ctrl
    import lane_ring_buffer_pkg::*;
#(
    parameter int BURST_LENGTH = DEF_BURST_LENGTH,
    parameter int DEPTH_BURSTS = DEF_DEPTH_BURSTS,
    localparam int DEPTH  = BURST_LENGTH * DEPTH_BURSTS,
    localparam int PTR_W  = ptr_w(BURST_LENGTH, DEPTH_BURSTS),
    localparam int BCNT_W = bcnt_w(BURST_LENGTH, DEPTH_BURSTS),
    localparam int CW     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_last,
    input  logic              pop_req,
    input  logic              head_last,
    input  logic              flush,
    output logic [PTR_W-1:0]  waddr,
    output logic [PTR_W-1:0]  raddr,
    output logic [CW-1:0]     count,
    output logic              valid,
    output logic              full,
    output logic              burst_space,
    output logic [BCNT_W-1:0] bursts_avail
);

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic          push_ok;
    logic          pop;
    logic          bump_up;
    logic          bump_down;

    // Modular difference of the wrap-extended pointers gives 0..DEPTH.
    assign count       = wptr - rptr;
    assign valid       = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign burst_space = (count <= CW'(DEPTH - BURST_LENGTH));
    assign waddr       = wptr[PTR_W-1:0];
    assign raddr       = rptr[PTR_W-1:0];

    // A flush swallows both sides of the lane for this cycle.
    assign push_ok   = push && !full && !flush;
    assign pop       = valid && pop_req && !flush;
    assign bump_up   = push_ok && push_last;
    assign bump_down = pop && head_last;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr         <= '0;
            rptr         <= '0;
            bursts_avail <= '0;
        end else begin
            if (push_ok) wptr <= wptr + CW'(1);
            if (pop)     rptr <= rptr + CW'(1);
            case ({bump_up, bump_down})
                2'b10:   bursts_avail <= bursts_avail + BCNT_W'(1);
                2'b01:   bursts_avail <= bursts_avail - BCNT_W'(1);
                default: bursts_avail <= bursts_avail;
            endcase
        end
    end

endmodule

// File: rtl/lane_ring_buffer.sv
// Multi-lane burst-aware ring buffer: one shared write stream demuxed by
// s_lane into NUM_LANE independent first-word-fall-through rings.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          write handshake; beat taken when both are high
//   s_lane, s_data, s_last   target lane, payload, burst-last marker
//   m_valid/m_ready          per-lane read handshake; pop when both are high
//   m_data, m_last           per-lane head entry (combinational read)
//   lane_flush               per-lane synchronous clear
//   lane_count               entries held per lane
//   burst_space              lane can take a full burst
//   bursts_avail             complete bursts held per lane
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never waits on valid, and m_ready on an empty lane is
// ignored.
module lane_ring_buffer
    import lane_ring_buffer_pkg::*;
#(
    // Storage uses entry_t, so the payload width follows DEF_DATA_WIDTH.
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BURST_LENGTH = DEF_BURST_LENGTH,
    parameter int NUM_LANE     = DEF_NUM_LANE,
    parameter int DEPTH_BURSTS = DEF_DEPTH_BURSTS,
    localparam int DEPTH  = BURST_LENGTH * DEPTH_BURSTS,
    localparam int LANE_W = lane_w(NUM_LANE),
    localparam int PTR_W  = ptr_w(BURST_LENGTH, DEPTH_BURSTS),
    localparam int BCNT_W = bcnt_w(BURST_LENGTH, DEPTH_BURSTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [LANE_W-1:0]              s_lane,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_last,
    output logic [NUM_LANE-1:0]            m_valid,
    input  logic [NUM_LANE-1:0]            m_ready,
    output logic [NUM_LANE*DATA_WIDTH-1:0] m_data,
    output logic [NUM_LANE-1:0]            m_last,
    input  logic [NUM_LANE-1:0]            lane_flush,
    output logic [NUM_LANE*(PTR_W+1)-1:0]  lane_count,
    output logic [NUM_LANE-1:0]            burst_space,
    output logic [NUM_LANE*BCNT_W-1:0]     bursts_avail
);

    entry_t           mem [NUM_LANE][DEPTH];
    logic [PTR_W-1:0] waddr [NUM_LANE];
    logic [PTR_W-1:0] raddr [NUM_LANE];
    logic [NUM_LANE-1:0] full;
    logic [NUM_LANE-1:0] lane_push;
    logic             lane_ok;
    logic             accept;

    // Lane indices beyond NUM_LANE (non power-of-two lane counts) are never ready.
    assign lane_ok = (32'(s_lane) < 32'(NUM_LANE));

    // No bypass: a full lane stays not-ready even if it pops this cycle.
    always_comb begin
        s_ready = 1'b0;
        if (!rst && lane_ok)
            s_ready = !full[s_lane] && !lane_flush[s_lane];
    end

    assign accept = s_valid && s_ready;

    // Storage is written only on an accepted beat and is never reset.
    always_ff @(posedge clk) begin
        if (accept)
            mem[s_lane][waddr[s_lane]] <= '{last: s_last, data: s_data};
    end

    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        assign lane_push[i] = accept && (s_lane == LANE_W'(i));
        assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][raddr[i]].data;
        assign m_last[i] = mem[i][raddr[i]].last;

        lane_ring_ctrl #(
            .BURST_LENGTH (BURST_LENGTH),
            .DEPTH_BURSTS (DEPTH_BURSTS)
        ) u_ctrl (
            .clk          (clk),
            .rst          (rst),
            .push         (lane_push[i]),
            .push_last    (s_last),
            .pop_req      (m_ready[i]),
            .head_last    (m_last[i]),
            .flush        (lane_flush[i]),
            .waddr        (waddr[i]),
            .raddr        (raddr[i]),
            .count        (lane_count[i*(PTR_W+1) +: (PTR_W+1)]),
            .valid        (m_valid[i]),
            .full         (full[i]),
            .burst_space  (burst_space[i]),
            .bursts_avail (bursts_avail[i*BCNT_W +: BCNT_W])
        );
    end

endmodule

// File: tb/tb_lane_ring_buffer.sv
// Self-checking bench for lane_ring_buffer: a queue-per-lane model checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_lane_ring_buffer;

    localparam int DW    = 32;
    localparam int BL    = 4;
    localparam int NL    = 4;
    localparam int DB    = 2;
    localparam int DEPTH = BL * DB;
    localparam int LW    = 2;
    localparam int CW    = 4;
    localparam int BW    = 4;

    bit              clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [LW-1:0]   s_lane;
    logic [DW-1:0]   s_data;
    logic            s_last;
    logic [NL-1:0]   m_valid;
    logic [NL-1:0]   m_ready;
    logic [NL*DW-1:0] m_data;
    logic [NL-1:0]   m_last;
    logic [NL-1:0]   lane_flush;
    logic [NL*CW-1:0] lane_count;
    logic [NL-1:0]   burst_space;
    logic [NL*BW-1:0] bursts_avail;

    lane_ring_buffer #(
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL),
        .NUM_LANE     (NL),
        .DEPTH_BURSTS (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_lane       (s_lane),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .lane_flush   (lane_flush),
        .lane_count   (lane_count),
        .burst_space  (burst_space),
        .bursts_avail (bursts_avail)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    // Model: each lane is a plain FIFO of {last, data}.
    logic [DW:0] mq [NL][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_bursts(input int lane);
        int n = 0;
        foreach (mq[lane][k]) if (mq[lane][k][DW]) n++;
        return n;
    endfunction

    // ---------------- scoreboard / compare ----------------
    // Inputs are stable from posedge+1 to the next posedge, so at negedge
    // the model both checks the current outputs and predicts the next edge.
    always @(negedge clk) begin
        logic          exp_ready;
        logic [NL-1:0] do_pop;
        int            sz;
        if (run_cmp) begin
            exp_ready = !rst && (mq[s_lane].size() != DEPTH) && !lane_flush[s_lane];
            check("s_ready", s_ready, exp_ready);
            for (int i = 0; i < NL; i++) begin
                sz = mq[i].size();
                check($sformatf("lane_count[%0d]", i), lane_count[i*CW +: CW], sz);
                check($sformatf("m_valid[%0d]", i), m_valid[i], sz > 0);
                check($sformatf("burst_space[%0d]", i), burst_space[i], (DEPTH - sz) >= BL);
                check($sformatf("bursts_avail[%0d]", i), bursts_avail[i*BW +: BW], model_bursts(i));
                if (sz > 0) begin
                    check($sformatf("m_data[%0d]", i), m_data[i*DW +: DW], mq[i][0][DW-1:0]);
                    check($sformatf("m_last[%0d]", i), m_last[i], mq[i][0][DW]);
                end
            end
            if (rst) begin
                for (int i = 0; i < NL; i++) mq[i].delete();
            end else begin
                for (int i = 0; i < NL; i++)
                    do_pop[i] = !lane_flush[i] && m_ready[i] && (mq[i].size() > 0);
                for (int i = 0; i < NL; i++) begin
                    if (lane_flush[i]) mq[i].delete();
                    else if (do_pop[i]) void'(mq[i].pop_front());
                end
                if (s_valid && exp_ready) mq[s_lane].push_back({s_last, s_data});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid    = 1'b0;
        m_ready    = '0;
        lane_flush = '0;
    endtask

    task automatic push(input int lane, input logic [DW-1:0] data, input logic last);
        s_valid = 1'b1;
        s_lane  = LW'(lane);
        s_data  = data;
        s_last  = last;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic flush_all();
        lane_flush = '1;
        cyc();
        lane_flush = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; s_valid = 1'b0; s_lane = '0; s_data = '0; s_last = 1'b0;
        m_ready = '0; lane_flush = '0;
        cyc();
        run_cmp = 1'b1;
        cyc();
        check("rst_m_valid", m_valid, 4'b0000);
        check("rst_lane_count", lane_count, 16'h0000);
        check("rst_burst_space", burst_space, 4'b1111);
        check("rst_bursts_avail", bursts_avail, 16'h0000);
        check("rst_s_ready", s_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_ready, 1'b1);

        // 1: one burst into lane 2
        for (int k = 0; k < 4; k++) push(2, DW'(32'hA0 + k), k == 3);
        check("s1_count", lane_count[2*CW +: CW], 4);
        check("s1_bursts", bursts_avail[2*BW +: BW], 1);
        check("s1_space", burst_space[2], 1'b1);
        check("s1_data", m_data[2*DW +: DW], 32'hA0);
        check("s1_valid", m_valid, 4'b0100);

        // 2: fill lane 1, then pop with a refused write
        for (int k = 0; k < 8; k++) push(1, $urandom(), (k % 4) == 3);
        check("s2_count_full", lane_count[1*CW +: CW], 8);
        s_lane = 2'd1; #1;
        check("s2_ready_full_lane", s_ready, 1'b0);
        s_lane = 2'd0; #1;
        check("s2_ready_other_lane", s_ready, 1'b1);
        s_valid = 1'b1; s_lane = 2'd1; s_data = 32'hDEAD; s_last = 1'b0;
        m_ready = 4'b0010;
        cyc();
        idle();
        check("s2_count_after_pop", lane_count[1*CW +: CW], 7);

        // 3: stream 0..19 through lane 0 with continuous pops
        flush_all();
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1; s_lane = 2'd0; s_data = DW'(k); s_last = (k % 4) == 3;
            m_ready = 4'b0001;
            cyc();
            check("s3_count_le2", lane_count[0 +: CW] <= 2, 1'b1);
        end
        s_valid = 1'b0;
        cyc(); cyc();
        idle();
        check("s3_drained", lane_count[0 +: CW], 0);

        // 4: pop a burst-last beat while writing a new burst-last beat
        flush_all();
        for (int k = 0; k < 8; k++) push(3, DW'(32'h300 + k), (k % 4) == 3);
        check("s4_bursts_two", bursts_avail[3*BW +: BW], 2);
        m_ready = 4'b1000;
        cyc(); cyc(); cyc();
        m_ready = '0;
        check("s4_head_last", m_last[3], 1'b1);
        check("s4_head_data", m_data[3*DW +: DW], 32'h303);
        s_valid = 1'b1; s_lane = 2'd3; s_data = 32'h3FF; s_last = 1'b1;
        m_ready = 4'b1000;
        cyc();
        idle();
        check("s4_bursts_kept", bursts_avail[3*BW +: BW], 2);
        check("s4_count", lane_count[3*CW +: CW], 5);

        // 5: flush lane 2 while pushing and popping it
        flush_all();
        push(0, 32'h55, 1'b0);
        push(0, 32'h56, 1'b1);
        for (int k = 0; k < 6; k++) push(2, DW'(32'h200 + k), k == 3);
        lane_flush = 4'b0100;
        s_valid = 1'b1; s_lane = 2'd2; s_data = 32'hBEEF; s_last = 1'b1;
        m_ready = 4'b0100;
        #1;
        check("s5_ready_flush", s_ready, 1'b0);
        cyc();
        idle();
        check("s5_count", lane_count[2*CW +: CW], 0);
        check("s5_bursts", bursts_avail[2*BW +: BW], 0);
        check("s5_valid", m_valid[2], 1'b0);
        check("s5_other_count", lane_count[0 +: CW], 2);
        check("s5_other_data", m_data[0 +: DW], 32'h55);

        // random traffic with occasional flushes
        flush_all();
        for (int n = 0; n < 400; n++) begin
            s_valid = $urandom_range(0, 3) != 0;
            s_lane  = LW'($urandom_range(0, NL - 1));
            s_data  = $urandom();
            s_last  = $urandom_range(0, 3) == 0;
            m_ready = NL'($urandom_range(0, 15)) & NL'($urandom_range(0, 15));
            lane_flush = ($urandom_range(0, 31) == 0) ? NL'(1 << $urandom_range(0, NL - 1)) : '0;
            cyc();
        end
        idle();

        // 6: reset mid-burst
        flush_all();
        for (int k = 0; k < 3; k++) push(0, DW'(32'h600 + k), 1'b0);
        push(1, 32'h700, 1'b1);
        rst = 1'b1;
        s_valid = 1'b1; s_lane = 2'd0; s_data = 32'h603; s_last = 1'b1;
        #1;
        check("s6_ready_in_rst", s_ready, 1'b0);
        cyc();
        rst = 1'b0;
        s_valid = 1'b0;
        check("s6_counts", lane_count, 16'h0000);
        check("s6_valid", m_valid, 4'b0000);
        check("s6_bursts", bursts_avail, 16'h0000);
        s_valid = 1'b1; s_lane = 2'd0; s_data = 32'h610; s_last = 1'b0;
        #1;
        check("s6_ready_after", s_ready, 1'b1);
        cyc();
        idle();
        check("s6_new_data", m_data[0 +: DW], 32'h610);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
